// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: loads an 8-bit word, drives it onto a downstream 8:1 mux and
// walks the select 0..7, sampling the returned mux output into a serial bit
// stream and a reassembled word.
// Optional build macro: MUX_SCAN_CTRL_CHECK_EN enables the word-compare check
// on o_mismatch; without it o_mismatch is tied low.
module mux_scan_ctrl #(
   parameter logic [7:0] IDLE_CODE = 8'h00
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_load_valid,
   input  logic [7:0] i_load_code,
   output logic       o_load_ready,
   output logic [7:0] o_code,
   output logic [2:0] o_sel_code,
   input  logic       i_f,
   output logic       o_bit,
   output logic [2:0] o_bit_idx,
   output logic       o_bit_valid,
   output logic       o_last,
   output logic [7:0] o_word,
   output logic       o_word_valid,
   output logic       o_busy,
   output logic       o_mismatch
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] code_q, code_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] word_q, word_d;
   logic       bit_q, bit_d;
   logic [2:0] idx_q, idx_d;
   logic       bv_q, bv_d;
   logic       last_q, last_d;
   logic       wv_q, wv_d;

   // State and datapath registers; reset returns everything to the idle image.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         code_q  <= IDLE_CODE;
         sel_q   <= 3'd0;
         word_q  <= 8'h00;
         bit_q   <= 1'b0;
         idx_q   <= 3'd0;
         bv_q    <= 1'b0;
         last_q  <= 1'b0;
         wv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         sel_q   <= sel_d;
         word_q  <= word_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         bv_q    <= bv_d;
         last_q  <= last_d;
         wv_q    <= wv_d;
      end
   end

   // Next-state: strobes default low, everything else holds unless enabled.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      sel_d   = sel_q;
      word_d  = word_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      bv_d    = 1'b0;
      last_d  = 1'b0;
      wv_d    = 1'b0;
      if (i_en) begin
         case (state_q)
            S_IDLE: begin
               if (i_load_valid) begin
                  code_d  = i_load_code;
                  word_d  = 8'h00;
                  sel_d   = 3'd0;
                  state_d = S_SCAN;
               end
            end
            S_SCAN: begin
               // i_f reflects the mux at the current select, so sample then advance.
               bit_d         = i_f;
               idx_d         = sel_q;
               bv_d          = 1'b1;
               word_d[sel_q] = i_f;
               sel_d         = sel_q + 3'd1;
               if (sel_q == 3'd7) begin
                  last_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               wv_d    = 1'b1;
               code_d  = IDLE_CODE;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

`ifdef MUX_SCAN_CTRL_CHECK_EN
   logic mm_q;
   // Compare the reassembled word with the driven word as the strobe is issued.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         mm_q <= 1'b0;
      else if (i_en)
         mm_q <= (state_q == S_DONE) && (word_q != code_q);
      else
         mm_q <= 1'b0;
   end
   assign o_mismatch = mm_q;
`else
   assign o_mismatch = 1'b0;
`endif

   assign o_load_ready = (state_q == S_IDLE) && i_en;
   assign o_busy       = (state_q != S_IDLE);
   assign o_code       = code_q;
   assign o_sel_code   = sel_q;
   assign o_word       = word_q;
   assign o_bit        = bit_q;
   assign o_bit_idx    = idx_q;
   assign o_bit_valid  = bv_q;
   assign o_last       = last_q;
   assign o_word_valid = wv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: ideal 8:1 mux (optionally forcing sel 2 to 0),
// a count-based reference model checked every cycle, and literal checks.
module tb_mux_scan_ctrl;

   localparam logic [7:0] IDLE_CODE = 8'h00;
`ifdef MUX_SCAN_CTRL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       i_clk, i_rst, i_en, i_load_valid, i_f;
   logic [7:0] i_load_code;
   logic       o_load_ready, o_bit, o_bit_valid, o_last, o_word_valid, o_busy, o_mismatch;
   logic [7:0] o_code, o_word;
   logic [2:0] o_sel_code, o_bit_idx;
   bit         fault_on;

   int n_cmp = 0;
   int n_err = 0;

   mux_scan_ctrl #(.IDLE_CODE(IDLE_CODE)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
      .i_load_valid(i_load_valid), .i_load_code(i_load_code),
      .o_load_ready(o_load_ready), .o_code(o_code), .o_sel_code(o_sel_code),
      .i_f(i_f), .o_bit(o_bit), .o_bit_idx(o_bit_idx), .o_bit_valid(o_bit_valid),
      .o_last(o_last), .o_word(o_word), .o_word_valid(o_word_valid),
      .o_busy(o_busy), .o_mismatch(o_mismatch)
   );

   // downstream mux, with an optional stuck-at-0 on input 2
   assign i_f = (fault_on && o_sel_code == 3'd2) ? 1'b0 : o_code[o_sel_code];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // busy + count of bits already sampled (0..8); count 8 means word complete.
   bit       m_busy = 0;
   int       m_cnt = 0;
   bit [7:0] m_code = IDLE_CODE, m_word = 0;
   bit       m_bit = 0, m_bv = 0, m_last = 0, m_wv = 0, m_mm = 0;
   bit [2:0] m_idx = 0;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_busy = 0; m_cnt = 0; m_code = IDLE_CODE; m_word = 0;
         m_bit = 0; m_idx = 0; m_bv = 0; m_last = 0; m_wv = 0; m_mm = 0;
      end else begin
         m_bv = 0; m_last = 0; m_wv = 0; m_mm = 0;
         if (i_en) begin
            if (!m_busy) begin
               if (i_load_valid) begin
                  m_code = i_load_code; m_word = 0; m_cnt = 0; m_busy = 1;
               end
            end else if (m_cnt < 8) begin
               m_bit = (fault_on && m_cnt == 2) ? 1'b0 : m_code[m_cnt];
               m_idx = 3'(m_cnt);
               m_word[m_cnt] = m_bit;
               m_bv = 1;
               m_cnt++;
               m_last = (m_cnt == 8);
            end else begin
               m_wv = 1;
               m_mm = CHK && (m_word != m_code);
               m_busy = 0;
               m_code = IDLE_CODE;
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge i_clk) begin
      check("ready", o_load_ready, (!m_busy && i_en));
      check("busy", o_busy, m_busy);
      check("code", o_code, m_code);
      check("sel", o_sel_code, (m_busy && m_cnt < 8) ? m_cnt : 0);
      check("word", o_word, m_word);
      check("bit", o_bit, m_bit);
      check("bit_idx", o_bit_idx, m_idx);
      check("bit_valid", o_bit_valid, m_bv);
      check("last", o_last, m_last);
      check("word_valid", o_word_valid, m_wv);
      check("mismatch", o_mismatch, m_mm);
   end

   // capture of the serial stream for literal checks
   bit [7:0] cap_bits;
   int       cap_pulses, cap_next_idx, cap_wv, cap_last_ok, cap_order_ok;
   bit [7:0] cap_word;
   bit       cap_mm;

   always @(negedge i_clk) begin
      if (o_bit_valid) begin
         cap_bits[o_bit_idx] = o_bit;
         if (int'(o_bit_idx) != cap_next_idx) cap_order_ok = 0;
         if (o_last != (o_bit_idx == 3'd7)) cap_last_ok = 0;
         cap_next_idx++;
         cap_pulses++;
      end
      if (o_word_valid) begin
         cap_wv++;
         cap_word = o_word;
         cap_mm = o_mismatch;
      end
   end

   task automatic cap_clear();
      cap_bits = 0; cap_pulses = 0; cap_next_idx = 0;
      cap_last_ok = 1; cap_order_ok = 1; cap_word = 0; cap_mm = 0;
   endtask

   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic load(input logic [7:0] c);
      i_load_valid = 1; i_load_code = c;
      tick();
      i_load_valid = 0;
   endtask

   task automatic wait_word(input string name);
      int start;
      start = cap_wv;
      for (int i = 0; i < 40 && cap_wv == start; i++) tick();
      check({name, "_done"}, (cap_wv > start), 1);
   endtask

   task automatic wait_idx(input logic [2:0] k, input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = o_bit_valid && (o_bit_idx == k);
      end
      check({name, "_idx_seen"}, seen, 1);
   endtask

   task automatic check_word(input string name, input logic [7:0] bits, input logic [7:0] w, input bit mm);
      check({name, "_bits"}, cap_bits, bits);
      check({name, "_pulses"}, cap_pulses, 8);
      check({name, "_order"}, cap_order_ok, 1);
      check({name, "_last"}, cap_last_ok, 1);
      check({name, "_word"}, cap_word, w);
      check({name, "_mm"}, cap_mm, mm);
   endtask

   initial begin
      i_rst = 1; i_en = 0; i_load_valid = 0; i_load_code = 0; fault_on = 0;
      cap_wv = 0;
      cap_clear();
      #12;
      check("rst_code", o_code, 8'h00);
      check("rst_busy", o_busy, 0);
      check("rst_word", o_word, 8'h00);
      check("rst_ready", o_load_ready, 0);
      tick();
      i_rst = 0; i_en = 1;
      #1;
      check("idle_ready", o_load_ready, 1);

      // A5 with ideal mux
      cap_clear();
      load(8'hA5);
      check("a5_busy", o_busy, 1);
      check("a5_code", o_code, 8'hA5);
      wait_word("a5");
      check_word("a5", 8'hA5, 8'hA5, 0);
      tick();
      check("a5_hold", o_word, 8'hA5);

      // 3C with an FF offered during scan
      cap_clear();
      load(8'h3C);
      i_load_valid = 1; i_load_code = 8'hFF;
      repeat (5) begin
         check("3c_not_ready", o_load_ready, 0);
         tick();
      end
      i_load_valid = 0;
      wait_word("3c");
      check_word("3c", 8'h3C, 8'h3C, 0);
      check("3c_ready_idle", o_load_ready, 1);
      check("3c_code_idle", o_code, IDLE_CODE);

      // 81 with a three-cycle enable stall after idx 3
      cap_clear();
      load(8'h81);
      wait_idx(3'd3, "81");
      i_en = 0;
      repeat (3) tick();
      check("81_stall_sel", o_sel_code, 3'd4);
      check("81_stall_pulses", cap_pulses, 4);
      i_en = 1;
      wait_word("81");
      check_word("81", 8'h81, 8'h81, 0);

      // reset mid-scan of F0 after idx 5, then 0F
      cap_clear();
      begin
         int wv0;
         wv0 = cap_wv;
         load(8'hF0);
         wait_idx(3'd5, "f0");
         i_rst = 1;
         #1;
         check("mid_rst_busy", o_busy, 0);
         check("mid_rst_code", o_code, 8'h00);
         check("mid_rst_sel", o_sel_code, 3'd0);
         check("mid_rst_word", o_word, 8'h00);
         check("mid_rst_bv", o_bit_valid, 0);
         check("mid_rst_idx", o_bit_idx, 3'd0);
         tick(); tick();
         i_rst = 0;
         check("f0_no_wv", cap_wv, wv0);
      end
      cap_clear();
      load(8'h0F);
      wait_word("0f");
      check_word("0f", 8'h0F, 8'h0F, 0);

      // stuck-at-0 on mux input 2
      fault_on = 1;
      cap_clear();
      load(8'h04);
      wait_word("04");
      check_word("04", 8'h00, 8'h00, CHK);
      fault_on = 0;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CODE, default 8'h00, the value driven on o_code while no word is loaded.
REQ-002 SHALL have i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have i_en  input  1  global enable; low freezes all state.
REQ-005 SHALL have i_load_valid  input  1  a load word is offered.
REQ-006 SHALL have i_load_code  input  8  the word to scan.
REQ-007 SHALL have o_load_ready  output  1  the block accepts a load this cycle.
REQ-008 SHALL have o_code  output  8  data bus to the downstream 8:1 mux.
REQ-009 SHALL have o_sel_code  output  3  select to the downstream 8:1 mux.
REQ-010 SHALL have i_f  input  1  mux output returned combinationally for the current o_sel_code.
REQ-011 SHALL have o_bit, o_bit_idx[2:0], o_bit_valid, o_last  outputs  registered serial stream of sampled bits.
REQ-012 SHALL have o_word[7:0], o_word_valid  outputs  reassembled word and its one-cycle strobe.
REQ-013 SHALL have o_busy  output  1  high in SCAN or DONE.
REQ-014 SHALL have o_mismatch  output  1  check result (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE; all transitions require i_en=1.
REQ-016 IDLE: o_load_ready = i_en; o_code = IDLE_CODE; o_sel_code = 0.
REQ-017 Accept on rising edge with i_load_valid & o_load_ready: latch i_load_code into o_code, clear o_word, set o_sel_code=0, go SCAN.
REQ-018 SCAN, each enabled edge with o_sel_code=k: o_bit<=i_f, o_bit_idx<=k, o_bit_valid<=1, o_word[k]<=i_f, o_sel_code<=k+1 (3-bit wrap).
REQ-019 SCAN with k=7: additionally o_last<=1 and go DONE; the wrapped o_sel_code=0 is not sampled.
REQ-020 Exactly 8 o_bit_valid pulses per word, idx 0..7 in order; first pulse one cycle after acceptance edge + 1 (sample-then-register latency 1).
REQ-021 o_bit_valid and o_last SHALL be low on any edge that does not sample.
REQ-022 DONE: o_word_valid<=1 for exactly one cycle, then IDLE; o_load_ready=0 in SCAN and DONE; loads offered there are ignored, not queued.
REQ-023 o_word SHALL hold its value after DONE until the next accepted load clears it.
REQ-024 i_en=0: state, o_sel_code, o_code, o_word frozen; o_bit_valid, o_last, o_word_valid forced low on that edge; scan resumes at the same k when i_en returns.
REQ-025 o_busy SHALL be high exactly in SCAN and DONE.

Reset
REQ-026 i_rst=1 SHALL immediately force IDLE, o_code=IDLE_CODE, o_sel_code=0, o_word=0, o_bit=0, o_bit_idx=0, and all valid/last/mismatch/busy flags low, including mid-scan.
REQ-027 After reset deasserts, the first acceptance SHALL be possible on the next enabled edge.

Configuration
REQ-028 Macro MUX_SCAN_CTRL_CHECK_EN defined: o_mismatch SHALL be 1 together with o_word_valid when the reassembled word differs from the latched o_code, else 0.
REQ-029 Macro undefined: check logic absent; o_mismatch tied 0.

Verification
REQ-030 Reset, load 8'hA5 with ideal mux model -> bits 1,0,1,0,0,1,0,1 at idx 0..7, o_last with idx 7, o_word=8'hA5 strobed, o_mismatch=0.
REQ-031 Load 8'h3C, offer 8'hFF during SCAN -> second word ignored, o_word=8'h3C, o_load_ready back high only in IDLE.
REQ-032 Load 8'h81, drop i_en for 3 cycles after idx 3 -> no pulses during stall, remaining idx 4..7 follow, o_word=8'h81.
REQ-033 Assert i_rst after idx 5 of 8'hF0 -> all outputs at reset values same cycle, no o_word_valid, next load 8'h0F scans cleanly.
REQ-034 CHECK_EN defined, mux model forcing i_f=0 at sel 2, load 8'h04 -> o_word=8'h00, o_mismatch=1 with o_word_valid; undefined -> o_mismatch=0.
